// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake bundle between uart_rx and its consumer.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic [7:0] data_received;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  // The receiver drives the byte and status; the consumer drives rx_ready.
  modport master (
    output data_received,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output overrun,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  modport slave (
    input  data_received,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  overrun,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready holding register.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the parity_err pulse on the interface.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | line idle, waiting for rx_s low
// S_START    | confirming the start bit at its centre (half_bit)
// S_DATA     | sampling 8 data bits LSB first at bit centre
// S_PARITY   | sampling the even-parity bit (UART_RX_PARITY_EN only)
// S_STOP     | sampling the stop bit, delivering the byte if good
// S_WAIT_IDLE| bad stop bit: hold off until the line returns high
module uart_rx #(
  parameter int clk_frequency = 27,
  parameter int baud_rate     = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  uart_rx_if.master  rx_if
);

  localparam int cycles_per_bit = (clk_frequency * 1_000_000) / baud_rate;
  localparam int half_bit       = cycles_per_bit / 2;
  localparam int CNT_W          = $clog2(cycles_per_bit);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       sync1_q, sync1_d;
  logic       rx_s_q, rx_s_d;
`ifdef UART_RX_PARITY_EN
  logic       parity_ok_q, parity_ok_d;
  logic       parity_err_q, parity_err_d;
`endif

  logic half_tick;
  logic bit_tick;
  logic stop_sample;
  logic deliver;
  logic accept;

  // State register plus all datapath flops, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_ok_q  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
`ifdef UART_RX_PARITY_EN
      parity_ok_q  <= parity_ok_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic; every sampling decision is taken on a counter tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s_q) state_d = S_START;
      S_START:     if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (bit_tick && bit_idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY:    if (bit_tick) state_d = S_STOP;
`else
      S_DATA:      if (bit_tick && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:      if (bit_tick) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output/strobe decode from the current state and counter.
  always_comb begin
    half_tick   = (cnt_q == CNT_W'(half_bit - 1));
    bit_tick    = (cnt_q == CNT_W'(cycles_per_bit - 1));
    stop_sample = (state_q == S_STOP) && bit_tick;
`ifdef UART_RX_PARITY_EN
    deliver     = stop_sample && rx_s_q && parity_ok_q;
`else
    deliver     = stop_sample && rx_s_q;
`endif
    accept      = valid_q && rx_if.rx_ready;
  end

  // Datapath next values: synchronizer, baud counter, shifter, holding register.
  always_comb begin
    sync1_d   = i_rx;
    rx_s_d    = sync1_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    // Counter restarts on every state entry and at the end of each bit period,
    // so consecutive data bits stay centred without leaving S_DATA.
    if (state_d != state_q || bit_tick ||
        state_q == S_IDLE || state_q == S_WAIT_IDLE)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    if (state_q == S_START && half_tick)
      bit_idx_d = 3'd0;
    if (state_q == S_DATA && bit_tick) begin
      shift_d[bit_idx_q] = rx_s_q;
      bit_idx_d          = bit_idx_q + 3'd1;
    end

`ifdef UART_RX_PARITY_EN
    parity_ok_d  = parity_ok_q;
    parity_err_d = 1'b0;
    if (state_q == S_PARITY && bit_tick) begin
      parity_ok_d  = (rx_s_q == ^shift_q);
      parity_err_d = (rx_s_q != ^shift_q);
    end
`endif

    // A new byte beats a same-cycle acceptance; overrun only if not accepted.
    data_d      = deliver ? shift_q : data_q;
    valid_d     = deliver ? 1'b1 : (accept ? 1'b0 : valid_q);
    overrun_d   = deliver && valid_q && !rx_if.rx_ready;
    frame_err_d = stop_sample && !rx_s_q;
  end

  assign rx_if.data_received = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.frame_err     = frame_err_q;
  assign rx_if.overrun       = overrun_q;
  assign rx_if.busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at the default 234 cycles per bit.
module tb_uart_rx;
  localparam int CLK_MHZ = 27;
  localparam int BAUD    = 115_200;
  localparam int CPB     = (CLK_MHZ * 1_000_000) / BAUD;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_rx;

  uart_rx_if rx_if();

  uart_rx #(.clk_frequency(CLK_MHZ), .baud_rate(BAUD)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_rx  (i_rx),
    .rx_if (rx_if)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rx_log[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Event monitor: logs each new rx_valid rise and counts status pulse cycles.
  always @(negedge i_clk) begin
    if (rx_if.rx_valid && !prev_valid) begin
      rx_log.push_back(rx_if.data_received);
      rise_cyc = cyc;
    end
    if (rx_if.frame_err) fe_cnt++;
    if (rx_if.overrun)   ov_cnt++;
    prev_valid = rx_if.rx_valid;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
  endtask

  int base;
  int fe_base;
  int ov_base;
  int lat;

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Reset state
    chk1 ("rst_valid",     rx_if.rx_valid,      1'b0);
    chk8 ("rst_data",      rx_if.data_received, 8'h00);
    chk1 ("rst_frame_err", rx_if.frame_err,     1'b0);
    chk1 ("rst_overrun",   rx_if.overrun,       1'b0);
    chk1 ("rst_busy",      rx_if.busy,          1'b0);

    // Single byte 0x5A, consumer not ready
    send_frame(8'h5A, 1'b1);
    repeat (2) @(negedge i_clk);
    chk1 ("5a_valid", rx_if.rx_valid,      1'b1);
    chk8 ("5a_data",  rx_if.data_received, 8'h5A);
    chk32("5a_fe",    fe_cnt,              0);
    lat = rise_cyc - start_cyc;
    chk1 ("5a_latency_window", (lat >= 2224 && lat <= 2227), 1'b1);
    rx_if.rx_ready = 1'b1;
    @(negedge i_clk);
    rx_if.rx_ready = 1'b0;
    chk1 ("5a_cleared", rx_if.rx_valid, 1'b0);
    chk8 ("5a_data_hold", rx_if.data_received, 8'h5A);

    // Back-to-back 0x00 then 0xFF with rx_ready held high
    rx_if.rx_ready = 1'b1;
    base    = rx_log.size();
    ov_base = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge i_clk);
    chk32("b2b_count",   rx_log.size() - base, 2);
    chk8 ("b2b_first",   rx_log[base],         8'h00);
    chk8 ("b2b_second",  rx_log[base + 1],     8'hFF);
    chk32("b2b_overrun", ov_cnt - ov_base,     0);

    // Bad stop bit followed by a 20-bit break, then a good byte
    base    = rx_log.size();
    fe_base = fe_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (20 * CPB) @(negedge i_clk);
    chk32("brk_fe_pulses", fe_cnt - fe_base,     1);
    chk1 ("brk_valid",     rx_if.rx_valid,       1'b0);
    chk1 ("brk_busy",      rx_if.busy,           1'b1);
    chk32("brk_no_byte",   rx_log.size() - base, 0);
    i_rx = 1'b1;
    repeat (5) @(negedge i_clk);
    chk1 ("brk_idle", rx_if.busy, 1'b0);
    rx_if.rx_ready = 1'b0;
    repeat (CPB) @(negedge i_clk);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge i_clk);
    chk1 ("3c_valid", rx_if.rx_valid,      1'b1);
    chk8 ("3c_data",  rx_if.data_received, 8'h3C);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge i_clk);

    // 50-cycle low glitch on an idle line
    base    = rx_log.size();
    fe_base = fe_cnt;
    i_rx = 1'b0;
    repeat (50) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge i_clk);
    chk32("glitch_no_byte", rx_log.size() - base, 0);
    chk32("glitch_no_fe",   fe_cnt - fe_base,     0);
    chk1 ("glitch_idle",    rx_if.busy,           1'b0);
    chk1 ("glitch_valid",   rx_if.rx_valid,       1'b0);

    // Overrun: 0x11 then 0x22 with nobody accepting
    rx_if.rx_ready = 1'b0;
    ov_base = ov_cnt;
    send_frame(8'h11, 1'b1);
    chk32("ovr_none_yet", ov_cnt - ov_base, 0);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge i_clk);
    chk32("ovr_pulse", ov_cnt - ov_base,     1);
    chk8 ("ovr_data",  rx_if.data_received,  8'h22);
    chk1 ("ovr_valid", rx_if.rx_valid,       1'b1);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge i_clk);

    // Two 0xAA back-to-back, then reset in the middle of 0x55
    base = rx_log.size();
    send_frame(8'hAA, 1'b1);
    send_frame(8'hAA, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk32("lb_count",  rx_log.size() - base, 2);
    chk8 ("lb_first",  rx_log[base],         8'hAA);
    chk8 ("lb_second", rx_log[base + 1],     8'hAA);
    chk1 ("lb_busy_mid", rx_if.busy,         1'b1);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk8 ("abort_data",  rx_if.data_received, 8'h00);
    chk1 ("abort_valid", rx_if.rx_valid,      1'b0);
    chk1 ("abort_busy",  rx_if.busy,          1'b0);
    chk1 ("abort_fe",    rx_if.frame_err,     1'b0);
    chk1 ("abort_ovr",   rx_if.overrun,       1'b0);
    fe_base = fe_cnt;
    repeat (12 * CPB) @(negedge i_clk);
    chk32("abort_no_byte", rx_log.size() - base, 2);
    chk32("abort_no_fe",   fe_cnt - fe_base,     0);
    chk1 ("abort_valid_late", rx_if.rx_valid,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of uart_tx on the same serial link. It recovers 8N1 frames from the asynchronous serial input, LSB first, idle-high. Each byte is handed to the fabric through a valid/ready holding register. It sits between the board RX pin and user logic, and shares the clk_frequency/baud_rate parameter scheme with uart_tx so a loopback pair is configured identically.

Parameters:
clk_frequency, 27, system clock frequency in MHz (integer)
baud_rate, 115_200, serial bit rate in bits/s
Derived: cycles_per_bit = (clk_frequency*1_000_000)/baud_rate, integer division (234 at defaults); half_bit = cycles_per_bit/2 (117)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_rx  input  1  asynchronous serial line, idle high
data_received  output  8  last good byte, stable while rx_valid=1
rx_valid  output  1  byte available in data_received
rx_ready  input  1  consumer accepts byte; transfer when rx_valid & rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new byte overwrote unaccepted byte
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; counters 0; both synchronizer flops 1; data_received=8'h00; rx_valid, frame_err, overrun, busy = 0. Reset aborts any frame in progress; a partial byte is discarded.
- Synchronizer: i_rx passes through 2 flops; the FSM uses only rx_s (the second flop). Pin-to-FSM latency is 2 cycles.
- Baud counter: width clog2(cycles_per_bit). Cleared on every state entry; counts 0..cycles_per_bit-1.
- FSM:
  - IDLE: rx_s=0 -> START.
  - START: when count = half_bit-1, sample rx_s. If 0 -> DATA (bit index 0). If 1 (glitch/false start) -> IDLE, no output.
  - DATA: when count = cycles_per_bit-1, shift rx_s into shift register bit[index]; index 7 -> STOP, else index+1. All samples are taken at bit centre.
  - STOP: when count = cycles_per_bit-1, sample rx_s.
    - If 1: data_received <= shift register; rx_valid <= 1; -> IDLE.
    - If 0: frame_err pulses 1 cycle, data is discarded, rx_valid is unchanged -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then -> IDLE. This prevents a held-low (break) line from retriggering START.
- Output handshake:
  - rx_valid stays high until a cycle with rx_valid & rx_ready, and clears on the next edge.
  - rx_ready is ignored while rx_valid=0.
  - If a good stop bit arrives while rx_valid=1 and not accepted in that same cycle: data_received is overwritten, rx_valid stays 1, overrun pulses 1 cycle.
  - If acceptance and a new byte land in the same cycle: the new byte wins, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 2 (sync) + half_bit + 9*cycles_per_bit cycles after the start-bit falling edge on i_rx (±1 cycle).
- Back-to-back frames: the FSM re-enters IDLE half a bit before the end of the stop bit, so a start edge immediately after the stop bit is caught.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. The FSM gains a PARITY state between DATA and STOP, sampled at bit centre, and a parity_err output (1-bit, one-cycle pulse). A mismatch against the even parity of the 8 data bits pulses parity_err, but the frame still completes. The byte is delivered only if both parity and stop bit are good. Latency gains one cycles_per_bit.
- Not defined: no PARITY state and no parity_err port; pure 8N1 as above.

Test Plan:
- Reset, then drive 8N1 byte 8'h5A at 234 cycles/bit with rx_ready=0 -> rx_valid=1, data_received=8'h5A, frame_err=0; pulse rx_ready for 1 cycle -> rx_valid=0 on the next edge.
- Bytes 8'h00 then 8'hFF back-to-back (no idle gap), rx_ready held 1 -> two rx_valid events with 8'h00 and 8'hFF, no overrun.
- Frame 8'hA5 with stop bit forced 0, then line held low 20 bit times -> one frame_err pulse, rx_valid stays 0, busy=1 until the line returns high, then byte 8'h3C received correctly.
- Low glitch of 50 cycles on an idle line -> returns to IDLE, no rx_valid, no frame_err.
- Send 8'h11 then 8'h22 with rx_ready=0 throughout -> overrun pulses once at the second stop bit, data_received=8'h22, rx_valid=1.
- Loopback: uart_tx o_tx -> uart_rx i_rx, send 8'hAA twice back-to-back, then assert i_rst mid-frame of a third byte 8'h55 -> two 8'hAA received; after reset all outputs are 0 and no byte is delivered from the aborted frame. With UART_RX_PARITY_EN defined, inject a wrong parity bit -> parity_err pulses and no rx_valid.
